// File: rtl/dcache_2way_ctrl.sv
// 2-way set-associative write-back / write-allocate data cache controller.
// Internal tag/data storage, per-set LRU, registered line-wide memory interface.
module dcache_2way_ctrl #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int LINE_W = 256,
  parameter int SETS   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [LINE_W-1:0] mem_data_i,
  input  logic              mem_ack_i,
  output logic [LINE_W-1:0] mem_data_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  input  logic [WORD_W-1:0] p1_data_i,
  input  logic [ADDR_W-1:0] p1_addr_i,
  input  logic              p1_MemRead_i,
  input  logic              p1_MemWrite_i,
  output logic [WORD_W-1:0] p1_data_o,
  output logic              p1_stall_o
);

  localparam int OFF_W  = $clog2(LINE_W / 8);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int BSEL_W = $clog2(WORD_W / 8);
  localparam int WSEL_W = $clog2(LINE_W / WORD_W);
  localparam int WS_W   = (WSEL_W > 0) ? WSEL_W : 1;
  localparam int LB_W   = $clog2(LINE_W);

  typedef enum logic [2:0] {
    S_IDLE,
    S_MISS,
    S_WRITEBACK,
    S_REFILL,
    S_REFILL_OK
  } state_t;

  state_t state_q, state_n;

  logic [SETS-1:0][1:0] valid_q;
  logic [SETS-1:0][1:0] dirty_q;
  logic [SETS-1:0]      lru_q;
  logic [TAG_W-1:0]     tag_q  [SETS][2];
  logic [LINE_W-1:0]    line_q [SETS][2];

  logic [TAG_W-1:0] p_tag;
  logic [IDX_W-1:0] idx;
  logic [WS_W-1:0]  wsel;
  logic [LB_W-1:0]  wofs;
  logic             req, hit0, hit1, hit, acc_hit;
  logic [LINE_W-1:0] hit_line;

  logic             victim_q, victim_n;
  logic             fill, wb_done;
  logic             mem_en_n, mem_wr_n;
  logic [ADDR_W-1:0] mem_addr_n, refill_addr;
  logic [LINE_W-1:0] mem_data_n;

  assign p_tag = p1_addr_i[ADDR_W-1:OFF_W+IDX_W];
  assign idx   = p1_addr_i[OFF_W+IDX_W-1:OFF_W];

  if (WSEL_W > 0) begin : g_wsel
    assign wsel = p1_addr_i[OFF_W-1:BSEL_W];
  end else begin : g_no_wsel
    assign wsel = '0;
  end

  if (BSEL_W > 0) begin : g_byte_bits
    logic unused_byte_bits;
    assign unused_byte_bits = ^p1_addr_i[BSEL_W-1:0];
  end

  assign wofs = LB_W'(wsel) << $clog2(WORD_W);

  assign req      = p1_MemRead_i | p1_MemWrite_i;
  assign hit0     = valid_q[idx][0] & (tag_q[idx][0] == p_tag);
  assign hit1     = valid_q[idx][1] & (tag_q[idx][1] == p_tag);
  assign hit      = hit0 | hit1;
  assign acc_hit  = req & hit;
  assign hit_line = hit1 ? line_q[idx][1] : line_q[idx][0];

  assign p1_stall_o  = req & ~hit;
  assign p1_data_o   = acc_hit ? hit_line[wofs +: WORD_W] : '0;
  assign refill_addr = {p_tag, idx, {OFF_W{1'b0}}};

  // Memory outputs are computed one cycle ahead and registered with the state.
  always_comb begin
    state_n    = state_q;
    victim_n   = victim_q;
    mem_en_n   = mem_enable_o;
    mem_wr_n   = mem_write_o;
    mem_addr_n = mem_addr_o;
    mem_data_n = mem_data_o;
    fill       = 1'b0;
    wb_done    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req && !hit) begin
          if (!valid_q[idx][0])      victim_n = 1'b0;
          else if (!valid_q[idx][1]) victim_n = 1'b1;
          else                       victim_n = lru_q[idx];
          state_n = S_MISS;
        end
      end
      S_MISS: begin
        mem_en_n = 1'b1;
        if (valid_q[idx][victim_q] && dirty_q[idx][victim_q]) begin
          mem_wr_n   = 1'b1;
          mem_addr_n = {tag_q[idx][victim_q], idx, {OFF_W{1'b0}}};
          mem_data_n = line_q[idx][victim_q];
          state_n    = S_WRITEBACK;
        end else begin
          mem_wr_n   = 1'b0;
          mem_addr_n = refill_addr;
          state_n    = S_REFILL;
        end
      end
      S_WRITEBACK: begin
        if (mem_ack_i) begin
          wb_done    = 1'b1;
          mem_wr_n   = 1'b0;
          mem_addr_n = refill_addr;
          state_n    = S_REFILL;
        end
      end
      S_REFILL: begin
        if (mem_ack_i) begin
          fill     = 1'b1;
          mem_en_n = 1'b0;
          mem_wr_n = 1'b0;
          state_n  = S_REFILL_OK;
        end
      end
      S_REFILL_OK: state_n = S_IDLE;
      default:     state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      victim_q     <= 1'b0;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      state_q      <= state_n;
      victim_q     <= victim_n;
      mem_enable_o <= mem_en_n;
      mem_write_o  <= mem_wr_n;
      mem_addr_o   <= mem_addr_n;
      mem_data_o   <= mem_data_n;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q <= '0;
      dirty_q <= '0;
      lru_q   <= '0;
    end else begin
      if (fill) begin
        valid_q[idx][victim_q] <= 1'b1;
        dirty_q[idx][victim_q] <= 1'b0;
      end
      if (wb_done) dirty_q[idx][victim_q] <= 1'b0;
      if (acc_hit) begin
        lru_q[idx] <= ~hit1;
        if (p1_MemWrite_i) dirty_q[idx][hit1] <= 1'b1;
      end
    end
  end

  // Tag and line contents carry no reset; validity alone qualifies them.
  always_ff @(posedge clk_i) begin
    if (fill) begin
      line_q[idx][victim_q] <= mem_data_i;
      tag_q[idx][victim_q]  <= p_tag;
    end else if (acc_hit && p1_MemWrite_i) begin
      line_q[idx][hit1][wofs +: WORD_W] <= p1_data_i;
    end
  end

endmodule

// File: tb/tb_dcache_2way_ctrl.sv
// Scoreboard bench for dcache_2way_ctrl: load results and memory transactions
// are compared against a shadow word map and a behavioural line memory.
module tb_dcache_2way_ctrl;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic [255:0] mem_data_i;
  logic         mem_ack_i;
  logic [255:0] mem_data_o;
  logic [31:0]  mem_addr_o;
  logic         mem_enable_o;
  logic         mem_write_o;
  logic [31:0]  p1_data_i;
  logic [31:0]  p1_addr_i;
  logic         p1_MemRead_i;
  logic         p1_MemWrite_i;
  logic [31:0]  p1_data_o;
  logic         p1_stall_o;

  dcache_2way_ctrl #(.ADDR_W(32), .WORD_W(32), .LINE_W(256), .SETS(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i),
    .mem_data_o(mem_data_o), .mem_addr_o(mem_addr_o),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o),
    .p1_data_i(p1_data_i), .p1_addr_i(p1_addr_i),
    .p1_MemRead_i(p1_MemRead_i), .p1_MemWrite_i(p1_MemWrite_i),
    .p1_data_o(p1_data_o), .p1_stall_o(p1_stall_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } txn_t;

  int n_checks = 0;
  int n_errors = 0;

  logic [31:0]  exp_q[$];
  txn_t         txn_log[$];
  int           dly_q[$];
  logic [31:0]  shadow [logic [31:0]];
  logic [255:0] mem_model [logic [31:0]];
  logic         resp_on   = 1'b1;
  logic         stray_ack = 1'b0;

  task automatic check_eq(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] waddr);
    if (waddr == 32'h40) return 32'h1111_1111;
    return {waddr[15:0], ~waddr[15:0]};
  endfunction

  function automatic logic [31:0] exp_word(input logic [31:0] addr);
    logic [31:0] wa;
    wa = {addr[31:2], 2'b00};
    if (shadow.exists(wa)) return shadow[wa];
    return init_word(wa);
  endfunction

  function automatic logic [255:0] exp_line(input logic [31:0] laddr);
    logic [255:0] l;
    for (int unsigned i = 0; i < 8; i++) l[i*32 +: 32] = exp_word(laddr + 32'(i * 4));
    return l;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] laddr);
    logic [255:0] l;
    if (mem_model.exists(laddr)) return mem_model[laddr];
    for (int unsigned i = 0; i < 8; i++) l[i*32 +: 32] = init_word(laddr + 32'(i * 4));
    return l;
  endfunction

  // Memory responder: acks each transaction a given number of cycles after it starts.
  initial begin
    int   cnt;
    int   cur_dly;
    txn_t cur;
    cnt = 0;
    cur_dly = 1;
    mem_ack_i = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      mem_ack_i = 1'b0;
      if (stray_ack) begin
        mem_ack_i = 1'b1;
        stray_ack = 1'b0;
      end else if (rst_i || !mem_enable_o || !resp_on) begin
        cnt = 0;
      end else begin
        if (cnt == 0) begin
          cur = '{mem_write_o, mem_addr_o, mem_data_o};
          txn_log.push_back(cur);
          cur_dly = (dly_q.size() > 0) ? dly_q.pop_front() : 1;
        end
        if (cnt == cur_dly) begin
          check_eq("mem_addr_stable", mem_addr_o, cur.addr);
          check_eq("mem_write_stable", mem_write_o, cur.wr);
          if (mem_write_o) mem_model[mem_addr_o] = mem_data_o;
          else             mem_data_i = mem_line(mem_addr_o);
          mem_ack_i = 1'b1;
          cnt = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  task automatic access(input string tag, input logic [31:0] addr, input logic wr,
                        input logic [31:0] wdata, input int exp_stall);
    int st;
    st = 0;
    p1_addr_i     = addr;
    p1_data_i     = wdata;
    p1_MemWrite_i = wr;
    p1_MemRead_i  = !wr;
    if (wr) shadow[{addr[31:2], 2'b00}] = wdata;
    else    exp_q.push_back(exp_word(addr));
    #1;
    while (p1_stall_o && st < 200) begin
      @(negedge clk_i);
      #1;
      st++;
    end
    check_eq({tag, "_stall"}, 256'(st), 256'(exp_stall));
    if (!wr && exp_q.size() > 0) check_eq({tag, "_data"}, p1_data_o, exp_q.pop_front());
    @(negedge clk_i);
    p1_MemRead_i  = 1'b0;
    p1_MemWrite_i = 1'b0;
  endtask

  task automatic expect_txn(input string tag, input logic wr, input logic [31:0] addr);
    txn_t t;
    check_eq({tag, "_present"}, 256'(txn_log.size() > 0), 256'(1));
    if (txn_log.size() > 0) begin
      t = txn_log.pop_front();
      check_eq({tag, "_wr"}, t.wr, wr);
      check_eq({tag, "_addr"}, t.addr, addr);
    end
  endtask

  initial begin
    txn_t t;
    rst_i = 1'b1;
    p1_addr_i = '0;
    p1_data_i = '0;
    p1_MemRead_i = 1'b0;
    p1_MemWrite_i = 1'b0;
    repeat (3) @(negedge clk_i);
    check_eq("rst_mem_enable", mem_enable_o, 1'b0);
    check_eq("rst_mem_write", mem_write_o, 1'b0);
    check_eq("rst_mem_addr", mem_addr_o, 32'h0);
    check_eq("rst_mem_data", mem_data_o, 256'h0);
    check_eq("rst_stall", p1_stall_o, 1'b0);
    check_eq("rst_data", p1_data_o, 32'h0);
    rst_i = 1'b0;
    @(negedge clk_i);

    // cold load of A
    dly_q.push_back(2);
    access("cold_A", 32'h40, 1'b0, 32'h0, 5);
    expect_txn("cold_A_fill", 1'b0, 32'h40);
    check_eq("cold_A_valid0", dut.valid_q[2][0], 1'b1);
    check_eq("cold_A_lru", dut.lru_q[2], 1'b1);

    // B fills way1, A refreshes LRU, C evicts clean B
    dly_q.push_back(1);
    access("load_B", 32'h440, 1'b0, 32'h0, 4);
    expect_txn("load_B_fill", 1'b0, 32'h440);
    check_eq("load_B_lru", dut.lru_q[2], 1'b0);
    access("hit_A", 32'h40, 1'b0, 32'h0, 0);
    check_eq("hit_A_lru", dut.lru_q[2], 1'b1);
    dly_q.push_back(3);
    access("load_C", 32'h840, 1'b0, 32'h0, 6);
    expect_txn("load_C_fill", 1'b0, 32'h840);
    check_eq("load_C_no_wb", 256'(txn_log.size()), 256'(0));
    access("rehit_A", 32'h40, 1'b0, 32'h0, 0);

    // store hit, read back
    access("store_A", 32'h4C, 1'b1, 32'hDEAD_BEEF, 0);
    access("load_A_c", 32'h4C, 1'b0, 32'h0, 0);
    check_eq("store_A_dirty", dut.dirty_q[2][0], 1'b1);

    // make way0 (dirty A) the LRU, then evict it
    access("hit_C", 32'h840, 1'b0, 32'h0, 0);
    dly_q.push_back(2);
    dly_q.push_back(1);
    p1_addr_i = 32'h440;
    p1_MemRead_i = 1'b1;
    repeat (3) @(negedge clk_i);
    check_eq("evict_first_write", mem_write_o, 1'b1);
    check_eq("evict_first_addr", mem_addr_o, 32'h40);
    check_eq("evict_first_word3", mem_data_o[127:96], 32'hDEAD_BEEF);
    p1_MemRead_i = 1'b0;
    access("evict_B", 32'h440, 1'b0, 32'h0, 4);
    check_eq("wb_txn_count", 256'(txn_log.size()), 256'(2));
    if (txn_log.size() > 0) begin
      t = txn_log[0];
      check_eq("wb_line", t.data, exp_line(32'h40));
    end
    expect_txn("evict_wb", 1'b1, 32'h40);
    expect_txn("evict_fill", 1'b0, 32'h440);
    check_eq("evict_dirty_cleared", dut.dirty_q[2][0], 1'b0);

    // store miss allocates then writes
    dly_q.push_back(1);
    access("store_miss", 32'h1044, 1'b1, 32'h5A5A_5A5A, 4);
    expect_txn("store_miss_fill", 1'b0, 32'h1040);
    check_eq("store_miss_dirty", dut.dirty_q[2][1], 1'b1);
    check_eq("store_miss_word1", dut.line_q[2][1][63:32], 32'h5A5A_5A5A);
    access("load_1044", 32'h1044, 1'b0, 32'h0, 0);

    // written-back A comes back from memory with the stored word
    dly_q.push_back(1);
    access("reload_A_c", 32'h4C, 1'b0, 32'h0, 4);
    expect_txn("reload_A_fill", 1'b0, 32'h40);

    // reset while waiting for a refill ack
    resp_on = 1'b0;
    p1_addr_i = 32'h80;
    p1_MemRead_i = 1'b1;
    repeat (4) @(negedge clk_i);
    check_eq("pre_rst_enable", mem_enable_o, 1'b1);
    check_eq("pre_rst_write", mem_write_o, 1'b0);
    check_eq("pre_rst_addr", mem_addr_o, 32'h80);
    #2 rst_i = 1'b1;
    #1;
    check_eq("async_rst_enable", mem_enable_o, 1'b0);
    check_eq("async_rst_addr", mem_addr_o, 32'h0);
    @(negedge clk_i);
    p1_MemRead_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    stray_ack = 1'b1;
    repeat (3) @(negedge clk_i);
    check_eq("stray_ack_enable", mem_enable_o, 1'b0);
    check_eq("post_rst_valid", dut.valid_q, 64'h0);
    check_eq("idle_stall", p1_stall_o, 1'b0);
    check_eq("idle_data", p1_data_o, 32'h0);
    resp_on = 1'b1;
    dly_q.push_back(1);
    access("post_rst_A", 32'h40, 1'b0, 32'h0, 4);
    expect_txn("post_rst_fill", 1'b0, 32'h40);

    repeat (2) @(negedge clk_i);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, errors so far %0d", n_errors);
    $fatal(1);
  end

endmodule

// File: doc/dcache_2way_ctrl.md
Name: dcache_2way_ctrl

Overview:
- Parametrised 2-way set-associative, write-back, write-allocate data cache between the CPU memory stage (p1_* port) and line-wide data memory (mem_* port).
- Successor of the one-way data cache. Adds configurable geometry, a second way with per-set LRU replacement, and internal tag/data storage.
- Stalls the CPU on miss, writes back a dirty victim, refills, then completes the access as a hit.

Parameters:
- ADDR_W, 32: byte address width.
- WORD_W, 32: CPU data width; power of 2, at least 8.
- LINE_W, 256: line width in bits, equal to the memory bus width; power-of-2 multiple of WORD_W.
- SETS, 32: number of sets; power of 2, at least 2.
- Derived: OFF_W = log2(LINE_W/8); IDX_W = log2(SETS); TAG_W = ADDR_W - IDX_W - OFF_W; WSEL_W = log2(LINE_W/WORD_W).

Ports:
- clk_i  in  1  clock; all state changes on posedge.
- rst_i  in  1  asynchronous, active-high reset.
- mem_data_i  in  LINE_W  refill data, valid in the cycle mem_ack_i=1.
- mem_ack_i  in  1  one-cycle pulse completing the current memory transaction.
- mem_data_o  out  LINE_W  victim line during write-back.
- mem_addr_o  out  ADDR_W  line-aligned address (low OFF_W bits 0).
- mem_enable_o  out  1  memory request; held until ack.
- mem_write_o  out  1  1 = write-back, 0 = refill read.
- p1_data_i  in  WORD_W  store data.
- p1_addr_i  in  ADDR_W  byte address; word select = [OFF_W-1:log2(WORD_W/8)]; lower bits ignored.
- p1_MemRead_i  in  1  load request.
- p1_MemWrite_i  in  1  store request; if both read and write are set, the access is treated as a store.
- p1_data_o  out  WORD_W  load data; 0 when there is no hit.
- p1_stall_o  out  1  = req & ~hit, combinational.

Behaviour:
- Storage: per set and way, valid, dirty, tag and line registers; one LRU bit per set naming the least-recently-used way. Reads are combinational.
- Hit: hit_w = valid & (tag == p1_addr_i[ADDR_W-1:OFF_W+IDX_W]). Both ways hitting is impossible by construction. hit = hit0 | hit1.
- Load hit: p1_data_o = selected word of the hit line in the same cycle, no stall. On the posedge, LRU <= the other way.
- Store hit: no stall. On the posedge, the selected word in the hit line <= p1_data_i, dirty <= 1, LRU <= the other way.
- Victim selection is evaluated in IDLE on a miss and latched in a register:
  - way0 if invalid;
  - else way1 if invalid;
  - else the LRU way.
- FSM states: IDLE, MISS, WRITEBACK, REFILL, REFILL_OK.
  - IDLE: req & ~hit -> MISS (latch victim).
  - MISS: victim valid & dirty -> WRITEBACK, setting mem_enable_o=1, mem_write_o=1, mem_addr_o={victim tag, index, 0}, mem_data_o=victim line. Otherwise -> REFILL, setting mem_enable_o=1, mem_write_o=0, mem_addr_o={p1 tag, index, 0}.
  - WRITEBACK: on mem_ack_i, clear the victim dirty bit, switch to a refill read (mem_write_o=0, refill address) and go -> REFILL. Without ack, hold.
  - REFILL: on mem_ack_i, victim line <= mem_data_i, tag <= p1 tag, valid <= 1, dirty <= 0, mem_enable_o <= 0, -> REFILL_OK. Without ack, hold.
  - REFILL_OK: -> IDLE. The access now hits, and the normal hit path performs the load/store and LRU update.
- Refill latency with no write-back: stall lasts 3 + N cycles, where N = cycles from enable to ack (N >= 1).
- Memory outputs are registered. mem_enable_o, mem_write_o and the memory address change only on a clock edge and stay stable while waiting for ack. mem_ack_i outside WRITEBACK/REFILL is ignored.
- The CPU holds p1_addr_i, p1_data_i and the request stable while p1_stall_o=1. Behaviour is undefined if it does not.
- Reset (any state, including mid-transaction): state=IDLE; every valid, dirty and LRU bit = 0; mem_enable_o=0, mem_write_o=0, mem_addr_o=0, mem_data_o=0. Any in-flight memory transaction is abandoned, and no fill or write-back completes after reset. Line and tag contents need not be cleared.
- No request (read=write=0): no state change, p1_stall_o=0, p1_data_o=0.

Test Plan:
(Defaults; addresses A=0x40, B=0x440 and C=0x840 all map to set 2 with tags 0, 1 and 2.)
- Cold load A after reset: stall is asserted, mem_enable_o=1 with mem_write_o=0 and addr 0x40. Ack with line word0=0x11111111, then the stall drops after REFILL_OK and p1_data_o=0x11111111. Way0 valid, LRU[2]=1.
- Load B, then load A, then load C: B fills way1. The load of A sets LRU[2]=1, so C evicts way1/B with no write-back. A still hits afterwards without stalling.
- Store 0xDEADBEEF to A+0xC (hit): no stall. The next load of A+0xC returns 0xDEADBEEF, way0 dirty=1.
- Dirty eviction, way0 as LRU: first cycle, mem_write_o=1 with addr 0x40 and mem_data_o word3=0xDEADBEEF. After ack, mem_write_o=0 with the new refill address, and the final stall length is 4 + both ack delays.
- Store miss to 0x1044 with p1_data_i=0x5A5A5A5A: refill, then a write hit, leaving the line dirty with word1=0x5A5A5A5A.
- Assert rst_i while in REFILL awaiting ack: mem_enable_o drops asynchronously and a later mem_ack_i is ignored. Re-loading A misses again.
